digit_serial_add_sched: RTL and testbench
=========================================

// Module: digit_serial_add_sched
// PURPOSE
//  Round-robin scheduler sharing one 4-bit digit-serial adder (add_* ports) between two requesters.
//  Accepts a WIDTH-bit x+y request and feeds it to the adder LSB nibble first.
//  Collects the sum nibbles and the final carry, then returns a registered result with requester ID.
//  Sits between the two operand sources and the shared digit-serial adder datapath.
// PARAMETERS
//  WIDTH  16  operand width in bits; must be a multiple of 4 and between 4 and 64
//             (adder burst counter is 4 bits, so one burst is at most 16 digits); NDIG = WIDTH/4
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      async active-low reset
//  req0_valid  in   1      requester 0 has an operand pair
//  req0_ready  out  1      requester 0 accepted (handshake on valid&ready)
//  req0_x      in   WIDTH  requester 0 operand x
//  req0_y      in   WIDTH  requester 0 operand y
//  req1_valid  in   1      requester 1 has an operand pair
//  req1_ready  out  1      requester 1 accepted
//  req1_x      in   WIDTH  requester 1 operand x
//  req1_y      in   WIDTH  requester 1 operand y
//  res_valid   out  1      result available
//  res_ready   in   1      result consumer ready
//  res_id      out  1      requester that owns the result
//  res_sum     out  WIDTH  x+y modulo 2^WIDTH
//  res_cout    out  1      carry out of the MSB
//  add_valid   out  1      drives the adder's in_valid; high for the whole burst
//  add_x       out  4      current x nibble to the adder
//  add_y       out  4      current y nibble to the adder
//  add_s       in   4      adder sum, combinational from the nibble sampled at the previous edge
//  add_c       in   1      adder carry out, same timing as add_s
// BEHAVIOUR
//  Reset: all outputs 0 (req*_ready, res_valid, res_id, res_sum, res_cout, add_valid, add_x, add_y).
//    - State = IDLE; round-robin pointer points at req1, so req0 wins the first tie.
//  Adder contract:
//    - The adder clears its carry on the first edge of an add_valid-high burst.
//    - It chains the carry while add_valid stays high.
//    - add_valid must drop for at least 1 cycle between bursts.
//  FSM IDLE -> RUN -> LAST -> RESP -> IDLE.
//  IDLE:
//    - reqN_ready = 1 combinationally only for the granted requester, and only when its valid = 1.
//    - Grant: if only one requester is valid, it wins; if both are valid, the one not served last wins.
//    - On handshake: latch x, y and the ID; set digit counter k = 0; go to RUN.
//  RUN (NDIG cycles):
//    - add_valid = 1; add_x/add_y = nibble k of the latched operands.
//    - Each edge with k >= 1: store add_s into res_sum nibble k-1.
//    - k increments every edge; after cycle NDIG-1, go to LAST.
//  LAST:
//    - add_valid = 0, which also provides the required inter-burst gap.
//    - At the edge: store add_s into nibble NDIG-1 and add_c into res_cout; go to RESP.
//  RESP:
//    - res_valid = 1; res_sum, res_cout and res_id stay stable until res_ready.
//    - On res_valid & res_ready: go to IDLE.
//  Latency: res_valid rises NDIG+1 edges after the accept edge (5 for WIDTH=16).
//  Throughput: 1 op per NDIG+3 cycles at best.
//  Ready rules:
//    - No req_ready outside IDLE. A request held during RUN/LAST/RESP waits.
//    - The waiting request is not dropped and is granted in the next IDLE.
//  add_x/add_y hold their last value outside RUN; the adder samples them but ignores them.
//  Reset mid-operation: the FSM aborts to IDLE immediately and the operation is lost.
//    - The adder shares rst_n, so its carry and counter also clear.
//  Arithmetic is unsigned modulo 2^WIDTH; res_cout is the true carry of the full-width add.
// CONFIGURATION
//  OVF_EN defined:
//    - Adds output res_ovf (1 bit) = signed two's-complement overflow.
//    - res_ovf = (x[MSB]==y[MSB]) & (res_sum[MSB]!=x[MSB]).
//    - Registered at the LAST edge, reset 0, held like res_sum.
//  OVF_EN undefined: port res_ovf and its logic are absent; all other behaviour is identical.
// TESTING
//  1. req0 0x1234+0x0FFF -> res_sum 0x2233, cout 0, id 0; res_valid 5 cycles after accept.
//  2. req1 0xFFFF+0x0001 -> res_sum 0x0000, cout 1, id 1; carry ripples through all 4 nibbles.
//  3. Both valid continuously: ops 0xFFFF+0x0001 (req0), then 0x0000+0x0000 (req1).
//     -> ids alternate 0,1,0,1; second result 0x0000 cout 0; no carry leaks between bursts.
//  4. res_ready low 10 cycles in RESP -> res_valid/res_sum stay stable; req*_ready and add_valid stay 0.
//  5. rst_n low during RUN k=2 -> all outputs 0 next cycle.
//     After release, 0x0001+0x0001 -> 0x0002 cout 0.
//  6. OVF_EN: 0x7FFF+0x0001 -> ovf 1, cout 0; 0x8000+0xFFFF -> 0x7FFF, ovf 1, cout 1.

Source files
------------

// File: rtl/digit_serial_add_sched_if.sv
// Bundle for the two request ports, the result port and the digit-serial adder port.
// The res_ovf wire exists only when OVF_EN is defined.
interface digit_serial_add_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_x;
    logic [WIDTH-1:0] req0_y;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_x;
    logic [WIDTH-1:0] req1_y;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
`ifdef OVF_EN
    logic             res_ovf;
`endif
    logic             add_valid;
    logic [3:0]       add_x;
    logic [3:0]       add_y;
    logic [3:0]       add_s;
    logic             add_c;

    // master: the environment (requesters, result sink, adder)
    modport master (
        output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
        output res_ready, add_s, add_c,
        input  req0_ready, req1_ready, res_valid, res_id, res_sum, res_cout,
`ifdef OVF_EN
        input  res_ovf,
`endif
        input  add_valid, add_x, add_y
    );

    // slave: the scheduler
    modport slave (
        input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
        input  res_ready, add_s, add_c,
        output req0_ready, req1_ready, res_valid, res_id, res_sum, res_cout,
`ifdef OVF_EN
        output res_ovf,
`endif
        output add_valid, add_x, add_y
    );
endinterface

// File: rtl/digit_serial_add_sched.sv
// Round-robin scheduler feeding one shared 4-bit digit-serial adder, LSB nibble first.
// Define OVF_EN to add the registered signed-overflow flag res_ovf.
//
// state | meaning
// IDLE  | grant one valid requester, latch its operands
// RUN   | stream nibble k to the adder, collect sum nibble k-1
// LAST  | adder idle (burst gap), collect top nibble and carry
// RESP  | hold result until consumer takes it
module digit_serial_add_sched #(
    parameter int WIDTH = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    digit_serial_add_sched_if.slave bus
);
    localparam int NDIG = WIDTH / 4;
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_RESP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] sum_q;
    logic             id_q;
    logic             cout_q;
    logic             last_q;
    logic [3:0]       k_q;
    logic [3:0]       ax_q;
    logic [3:0]       ay_q;
    logic             grant1;
    logic             accept;
    logic             last_dig;
    logic [3:0]       k_nx;
    logic [3:0]       wr_idx;
    logic             wr_en;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
`ifdef OVF_EN
    logic             ovf_q;
`endif

    // last_q remembers who was served last; resetting to 1 makes req0 win the first tie
    assign grant1   = bus.req1_valid & (~bus.req0_valid | ~last_q);
    assign accept   = (state == S_IDLE) & (bus.req0_valid | bus.req1_valid);
    assign last_dig = (k_q == 4'(NDIG - 1));
    assign k_nx     = k_q + 4'd1;
    assign sel_x    = grant1 ? bus.req1_x : bus.req0_x;
    assign sel_y    = grant1 ? bus.req1_y : bus.req0_y;
    assign wr_idx   = (state == S_LAST) ? 4'(NDIG - 1) : (k_q - 4'd1);
    assign wr_en    = ((state == S_RUN) & (k_q != 4'd0)) | (state == S_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_RUN;
            S_RUN:   if (last_dig) state_nx = S_LAST;
            S_LAST:  state_nx = S_RESP;
            S_RESP:  if (bus.res_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.add_valid  = 1'b0;
        bus.res_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req0_ready = bus.req0_valid & ~grant1;
                bus.req1_ready = grant1;
            end
            S_RUN:   bus.add_valid = 1'b1;
            S_RESP:  bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    // operand nibbles are registered one step ahead so add_x/add_y hold outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
            k_q    <= 4'd0;
            ax_q   <= 4'd0;
            ay_q   <= 4'd0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    x_q    <= sel_x;
                    y_q    <= sel_y;
                    id_q   <= grant1;
                    last_q <= grant1;
                    k_q    <= 4'd0;
                    ax_q   <= sel_x[3:0];
                    ay_q   <= sel_y[3:0];
                end
                S_RUN: begin
                    k_q <= k_nx;
                    if (!last_dig) begin
                        ax_q <= 4'(x_q >> {k_nx, 2'b00});
                        ay_q <= 4'(y_q >> {k_nx, 2'b00});
                    end
                end
                S_LAST:  cout_q <= bus.add_c;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (wr_en && (wr_idx == 4'(i))) sum_q[4*i +: 4] <= bus.add_s;
            end
        end
    end

`ifdef OVF_EN
    // add_s[3] at the LAST edge is the MSB of the full sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               ovf_q <= 1'b0;
        else if (state == S_LAST) ovf_q <= (x_q[MSB] == y_q[MSB]) & (bus.add_s[3] != x_q[MSB]);
    end
    assign bus.res_ovf = ovf_q;
`endif

    assign bus.res_id   = id_q;
    assign bus.res_sum  = sum_q;
    assign bus.res_cout = cout_q;
    assign bus.add_x    = ax_q;
    assign bus.add_y    = ay_q;
endmodule

// File: tb/tb_digit_serial_add_sched.sv
// Bench for digit_serial_add_sched: behavioural digit-serial adder plus a plain-arithmetic result model.
module tb_digit_serial_add_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   last_id = 1'b1;

    always #5 clk = ~clk;

    digit_serial_add_sched_if #(.WIDTH(16)) bus();

    digit_serial_add_sched #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // shared adder: carry cleared on the first edge of a burst, chained while add_valid stays high
    logic [3:0] a_s;
    logic       a_c;
    logic       a_pv;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s  <= 4'd0;
            a_c  <= 1'b0;
            a_pv <= 1'b0;
        end else begin
            if (bus.add_valid)
                {a_c, a_s} <= 5'(bus.add_x) + 5'(bus.add_y) + 5'(a_pv ? a_c : 1'b0);
            a_pv <= bus.add_valid;
        end
    end
    assign bus.add_s = a_s;
    assign bus.add_c = a_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        logic [31:0] flat;
        flat = {bus.req0_ready, bus.req1_ready, bus.res_valid, bus.res_id, bus.res_cout,
                bus.add_valid, bus.add_x, bus.add_y, 2'b00};
`ifdef OVF_EN
        flat[0] = bus.res_ovf;
`endif
        chk({tag, "_ctl"}, flat, 32'd0);
        chk({tag, "_sum"}, 32'(bus.res_sum), 32'd0);
    endtask

    // one complete operation starting in IDLE at posedge+1
    task automatic do_op(input bit v0, input bit v1, input logic [15:0] x0, input logic [15:0] y0,
                         input logic [15:0] x1, input logic [15:0] y1, input int hold);
        bit          eid;
        logic [15:0] ex, ey, s0;
        logic [16:0] full;
        int          n, burst;
        bit          busy_rdy, stable;
        eid  = (v0 && v1) ? !last_id : v1;
        ex   = eid ? x1 : x0;
        ey   = eid ? y1 : y0;
        full = {1'b0, ex} + {1'b0, ey};
        bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0;
        bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1;
        #1;
        chk("ready0", 32'(bus.req0_ready), 32'(v0 && !eid));
        chk("ready1", 32'(bus.req1_ready), 32'(eid));
        @(posedge clk);
        last_id = eid;
        #1;
        n = 0; burst = 0; busy_rdy = 1'b0;
        while (!bus.res_valid && n < 20) begin
            burst += int'(bus.add_valid);
            busy_rdy |= bus.req0_ready | bus.req1_ready;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd5);
        chk("burst_len", 32'(burst), 32'd4);
        chk("res_id", 32'(bus.res_id), 32'(eid));
        chk("res_sum", 32'(bus.res_sum), 32'(full[15:0]));
        chk("res_cout", 32'(bus.res_cout), 32'(full[16]));
`ifdef OVF_EN
        chk("res_ovf", 32'(bus.res_ovf), 32'((ex[15] == ey[15]) && (full[15] != ex[15])));
`endif
        s0 = bus.res_sum;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            stable &= bus.res_valid && (bus.res_sum == s0) && (bus.res_id == eid) && !bus.add_valid;
            busy_rdy |= bus.req0_ready | bus.req1_ready;
        end
        if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
        chk("no_ready_busy", 32'(busy_rdy), 32'd0);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("res_drop", 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
        bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
        bus.res_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(1'b1, 1'b0, 16'h1234, 16'h0FFF, 16'h0000, 16'h0000, 0);
        do_op(1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 0);

        for (int i = 0; i < 4; i++)
            do_op(1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0);

        do_op(1'b1, 1'b1, 16'hA5A5, 16'h5A5B, 16'h0F0F, 16'hF0F1, 10);

        // abort mid-burst at k=2
        bus.req0_valid = 1'b1; bus.req0_x = 16'h3210; bus.req0_y = 16'h7654;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("k2_add_x", 32'(bus.add_x), 32'h2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        last_id = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(1'b1, 1'b0, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 0);

        for (int i = 0; i < 12; i++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            do_op(v0, v1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 3)));
        end

`ifdef OVF_EN
        do_op(1'b1, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 0);
        do_op(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 0);
`endif

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
